// File: rtl/isa_pkg.sv
// ISA definitions shared by the instruction encoder: mnemonics, opcode/extension
// nibbles, shift-immediate k-codes and the encoder FSM state type.
package isa_pkg;

    typedef enum logic [4:0] {
        ADD,  ADDU,  ADDC,  ADDCU,  SUB,  CMP,  CMPU,  AND,
        OR,   XOR,   NOT,   LSH,    RSH,  ALSH, ARSH,  ADDI,
        ADDUI, ADDCI, ADDCUI, SUBI, CMPI, CMPUI, ANDI,  ORI,
        XORI, LSHI,  RSHI,  ALSHI,  ARSHI, LOAD, STOR,  NOP
    } mnem_e;

    // Upper-nibble opcodes
    localparam logic [3:0] OP_RTYPE  = 4'b0000;
    localparam logic [3:0] OP_MEM    = 4'b0100;
    localparam logic [3:0] OP_SHIFT  = 4'b1000;
    localparam logic [3:0] OP_ANDI   = 4'b0001;
    localparam logic [3:0] OP_ORI    = 4'b0010;
    localparam logic [3:0] OP_XORI   = 4'b0011;
    localparam logic [3:0] OP_ADDI   = 4'b0101;
    localparam logic [3:0] OP_ADDUI  = 4'b0110;
    localparam logic [3:0] OP_ADDCI  = 4'b0111;
    localparam logic [3:0] OP_SUBI   = 4'b1001;
    localparam logic [3:0] OP_ADDCUI = 4'b1010;
    localparam logic [3:0] OP_CMPI   = 4'b1011;
    localparam logic [3:0] OP_CMPUI  = 4'b1100;

    // Extension nibbles for register-register forms (op 0000)
    localparam logic [3:0] EXT_AND   = 4'b0001;
    localparam logic [3:0] EXT_OR    = 4'b0010;
    localparam logic [3:0] EXT_XOR   = 4'b0011;
    localparam logic [3:0] EXT_ADDCU = 4'b0100;
    localparam logic [3:0] EXT_ADD   = 4'b0101;
    localparam logic [3:0] EXT_ADDU  = 4'b0110;
    localparam logic [3:0] EXT_ADDC  = 4'b0111;
    localparam logic [3:0] EXT_SUB   = 4'b1001;
    localparam logic [3:0] EXT_CMP   = 4'b1011;
    localparam logic [3:0] EXT_CMPU  = 4'b1100;
    localparam logic [3:0] EXT_NOT   = 4'b1111;

    // Register shifts (op 1000); chosen to avoid the shift-immediate k ranges
    localparam logic [3:0] EXT_LSH   = 4'b0100;
    localparam logic [3:0] EXT_RSH   = 4'b0101;
    localparam logic [3:0] EXT_ALSH  = 4'b0110;
    localparam logic [3:0] EXT_ARSH  = 4'b0111;

    // Memory forms (op 0100)
    localparam logic [3:0] EXT_LOAD  = 4'b0000;
    localparam logic [3:0] EXT_STOR  = 4'b0100;

    // Shift-immediate k-codes in bits [7:5]
    localparam logic [2:0] K_LSHI    = 3'b000;
    localparam logic [2:0] K_RSHI    = 3'b001;
    localparam logic [2:0] K_ALSHI   = 3'b100;
    localparam logic [2:0] K_ARSHI   = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } enc_state_e;

endpackage

// File: rtl/instr_encode_core.sv
// Combinational packer: one symbolic instruction -> 16-bit instruction word,
// flagging shift immediates outside -16..15 as illegal.
module instr_encode_core
    import isa_pkg::*;
(
    input  logic [4:0]  mnem_i,
    input  logic [3:0]  rdest_i,
    input  logic [3:0]  rsrc_i,
    input  logic [7:0]  imm_i,
    output logic [15:0] word_o,
    output logic        illegal_o
);

    mnem_e      m;
    logic       shamt_ok;
    logic [3:0] ext;
    logic [3:0] op;
    logic [2:0] k;

    assign shamt_ok = (imm_i[7:5] == {3{imm_i[4]}});

    always_comb begin
        m         = mnem_e'(mnem_i);
        word_o    = '0;
        illegal_o = 1'b0;
        ext       = '0;
        op        = '0;
        k         = '0;
        unique case (m)
            ADD, ADDU, ADDC, ADDCU, SUB, CMP, CMPU, AND, OR, XOR, NOT: begin
                unique case (m)
                    ADD:     ext = EXT_ADD;
                    ADDU:    ext = EXT_ADDU;
                    ADDC:    ext = EXT_ADDC;
                    ADDCU:   ext = EXT_ADDCU;
                    SUB:     ext = EXT_SUB;
                    CMP:     ext = EXT_CMP;
                    CMPU:    ext = EXT_CMPU;
                    AND:     ext = EXT_AND;
                    OR:      ext = EXT_OR;
                    XOR:     ext = EXT_XOR;
                    default: ext = EXT_NOT;
                endcase
                word_o = {OP_RTYPE, rdest_i, ext, rsrc_i};
            end
            LSH, RSH, ALSH, ARSH: begin
                unique case (m)
                    LSH:     ext = EXT_LSH;
                    RSH:     ext = EXT_RSH;
                    ALSH:    ext = EXT_ALSH;
                    default: ext = EXT_ARSH;
                endcase
                word_o = {OP_SHIFT, rdest_i, ext, rsrc_i};
            end
            ADDI, ADDUI, ADDCI, ADDCUI, SUBI, CMPI, CMPUI, ANDI, ORI, XORI: begin
                unique case (m)
                    ADDI:    op = OP_ADDI;
                    ADDUI:   op = OP_ADDUI;
                    ADDCI:   op = OP_ADDCI;
                    ADDCUI:  op = OP_ADDCUI;
                    SUBI:    op = OP_SUBI;
                    CMPI:    op = OP_CMPI;
                    CMPUI:   op = OP_CMPUI;
                    ANDI:    op = OP_ANDI;
                    ORI:     op = OP_ORI;
                    default: op = OP_XORI;
                endcase
                word_o = {op, rdest_i, imm_i};
            end
            LSHI, RSHI, ALSHI, ARSHI: begin
                unique case (m)
                    LSHI:    k = K_LSHI;
                    RSHI:    k = K_RSHI;
                    ALSHI:   k = K_ALSHI;
                    default: k = K_ARSHI;
                endcase
                word_o    = {OP_SHIFT, rdest_i, k, imm_i[4:0]};
                illegal_o = !shamt_ok;
            end
            LOAD:    word_o = {OP_MEM, rdest_i, EXT_LOAD, rsrc_i};
            STOR:    word_o = {OP_MEM, rdest_i, EXT_STOR, rsrc_i};
            default: word_o = '0;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Program-image builder: accepts symbolic instructions over a valid/ready
// handshake and streams encoded words into BRAM with an auto-incrementing address.
module instr_encoder #(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0,
    parameter int DEPTH     = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [4:0]        mnem,
    input  logic [3:0]        rdest,
    input  logic [3:0]        rsrc,
    input  logic [7:0]        imm,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_din,
    output logic              busy,
    output logic              done,
    output logic              err_imm,
    output logic              full,
    output logic [ADDR_W:0]   word_count
);

    import isa_pkg::*;

    localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   DEPTH_W = (ADDR_W + 1)'(DEPTH);

    enc_state_e        state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W:0]   count_q, count_d, count_inc;
    logic              err_q, err_d;
    logic              full_q, full_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       din_q, din_d;
    logic              done_q, done_d;
    logic [15:0]       word;
    logic              illegal;
    logic              accept;
    logic              finish;

    instr_encode_core u_core (
        .mnem_i    (mnem),
        .rdest_i   (rdest),
        .rsrc_i    (rsrc),
        .imm_i     (imm),
        .word_o    (word),
        .illegal_o (illegal)
    );

    assign accept    = (state_q == S_RUN) && !full_q && in_valid;
    assign count_inc = count_q + 1'b1;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        err_d   = err_q;
        full_d  = full_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        din_d   = din_q;
        done_d  = 1'b0;
        finish  = 1'b0;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_RUN;
                    ptr_d   = BASE;
                    count_d = '0;
                    err_d   = 1'b0;
                    full_d  = 1'b0;
                end
            end
            S_RUN: begin
                if (accept) begin
                    finish = in_last;
                    if (illegal) begin
                        err_d = 1'b1;
                    end else begin
                        // Write, pointer and count all land on the same edge
                        we_d    = 1'b1;
                        addr_d  = ptr_q;
                        din_d   = word;
                        ptr_d   = ptr_q + 1'b1;
                        count_d = count_inc;
                        if (count_inc == DEPTH_W) begin
                            full_d = 1'b1;
                            finish = 1'b1;
                        end
                    end
                    if (finish) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            ptr_q   <= BASE;
            count_q <= '0;
            err_q   <= 1'b0;
            full_q  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= BASE;
            din_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
            err_q   <= err_d;
            full_q  <= full_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            done_q  <= done_d;
        end
    end

    assign in_ready   = (state_q == S_RUN) && !full_q;
    assign busy       = (state_q == S_RUN);
    assign done       = done_q;
    assign err_imm    = err_q;
    assign full       = full_q;
    assign word_count = count_q;
    assign mem_we     = we_q;
    assign mem_addr   = addr_q;
    assign mem_din    = din_q;

endmodule
